// File: rtl/elevator_dispatcher.sv
// Two-car, four-floor group dispatcher: latches hall calls, scans them round-robin,
// costs both cars and hands each call to the cheaper one until that car opens its door there.
module elevator_dispatcher #(
  parameter int MOVE_PENALTY = 4,
  parameter int COST_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] hall_btn,
  input  logic [1:0] carA_floor,
  input  logic [1:0] carA_dir,
  input  logic       carA_door,
  input  logic       carA_en,
  input  logic [1:0] carB_floor,
  input  logic [1:0] carB_dir,
  input  logic       carB_door,
  input  logic       carB_en,
  output logic [5:0] hall_led,
  output logic [5:0] carA_call,
  output logic [5:0] carB_call,
  output logic       grant_vld,
  output logic       grant_car,
  output logic [2:0] grant_idx
);

  typedef enum logic [1:0] {IDLE, PICK, COST, GRANT} state_t;

  state_t              state, state_nxt;
  logic [5:0]          pend, asg_a, asg_b;
  logic [2:0]          rr_ptr;
  logic                tie_last;
  logic [2:0]          cur_p1;
  logic [COST_W-1:0]   cost_a_p2, cost_b_p2;

  logic                do_grant, win_b, tie;
  logic [5:0]          cur_oh, ret_a, ret_b, set_a, set_b, busy;

  function automatic logic [1:0] call_floor(input logic [2:0] idx);
    case (idx)
      3'd0:       return 2'd0;
      3'd1, 3'd2: return 2'd1;
      3'd3, 3'd4: return 2'd2;
      default:    return 2'd3;
    endcase
  endfunction

  function automatic logic [5:0] floor_mask(input logic [1:0] f);
    case (f)
      2'd0:    return 6'b000001;
      2'd1:    return 6'b000110;
      2'd2:    return 6'b011000;
      default: return 6'b100000;
    endcase
  endfunction

  function automatic logic [COST_W-1:0] car_cost(input logic [1:0] floor, input logic [1:0] dir,
                                                 input logic en, input logic [1:0] cf);
    logic [COST_W-1:0] c;
    if (!en) return '1;
    c = (floor > cf) ? COST_W'(floor - cf) : COST_W'(cf - floor);
    if ((dir == 2'b10 && cf < floor) || (dir == 2'b01 && cf > floor))
      c = c + COST_W'(MOVE_PENALTY);
    return c;
  endfunction

  function automatic logic [2:0] rr_pick(input logic [5:0] req, input logic [2:0] ptr);
    logic [2:0] sel;
    logic [3:0] s;
    logic       found;
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s = {1'b0, ptr} + 4'(i);
      if (s >= 4'd6) s = s - 4'd6;
      if (!found && req[s[2:0]]) begin
        sel   = s[2:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Winner selection: a lone enabled car wins outright, otherwise cheapest, ties alternate
  always_comb begin
    tie   = 1'b0;
    win_b = 1'b0;
    if (carA_en && !carB_en)       win_b = 1'b0;
    else if (!carA_en && carB_en)  win_b = 1'b1;
    else if (cost_b_p2 < cost_a_p2) win_b = 1'b1;
    else if (cost_a_p2 < cost_b_p2) win_b = 1'b0;
    else begin
      tie   = 1'b1;
      win_b = ~tie_last;
    end
  end

  assign do_grant = (state == GRANT) && (carA_en || carB_en);
  assign cur_oh   = 6'b000001 << cur_p1;
  assign ret_a    = carA_door ? floor_mask(carA_floor) : 6'b0;
  assign ret_b    = carB_door ? floor_mask(carB_floor) : 6'b0;
  assign set_a    = (do_grant && !win_b) ? cur_oh : 6'b0;
  assign set_b    = (do_grant &&  win_b) ? cur_oh : 6'b0;
  // A bit being retired this cycle no longer blocks a fresh press
  assign busy     = pend | (asg_a & ~ret_a) | (asg_b & ~ret_b);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pend != 6'b0 && (carA_en || carB_en)) state_nxt = PICK;
      PICK:    state_nxt = COST;
      COST:    state_nxt = GRANT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pend     <= 6'b0;
      asg_a    <= 6'b0;
      asg_b    <= 6'b0;
      rr_ptr   <= 3'd0;
      tie_last <= 1'b1;
    end else begin
      state <= state_nxt;
      pend  <= (pend & ~(do_grant ? cur_oh : 6'b0)) | (hall_btn & ~busy);
      asg_a <= (asg_a | set_a) & ~ret_a;
      asg_b <= (asg_b | set_b) & ~ret_b;
      if (do_grant) begin
        rr_ptr <= (cur_p1 == 3'd5) ? 3'd0 : cur_p1 + 3'd1;
        if (tie && carA_en && carB_en) tie_last <= win_b;
      end
    end
  end

  // Stage p1: selected call; stage p2: per-car cost of that call
  always_ff @(posedge clk) begin
    if (state == PICK) cur_p1 <= rr_pick(pend, rr_ptr);
    if (state == COST) begin
      cost_a_p2 <= car_cost(carA_floor, carA_dir, carA_en, call_floor(cur_p1));
      cost_b_p2 <= car_cost(carB_floor, carB_dir, carB_en, call_floor(cur_p1));
    end
  end

  assign hall_led  = pend | asg_a | asg_b;
  assign carA_call = asg_a;
  assign carB_call = asg_b;
  assign grant_vld = do_grant;
  assign grant_car = do_grant & win_b;
  assign grant_idx = do_grant ? cur_p1 : 3'd0;

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Bench for elevator_dispatcher: cost/winner vector table, hand-written corner sequences
// and a randomized run against a call-ownership reference model.
module tb_elevator_dispatcher;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] hall_btn = '0;
  logic [1:0] carA_floor = '0, carA_dir = '0, carB_floor = '0, carB_dir = '0;
  logic       carA_door = 1'b0, carA_en = 1'b1, carB_door = 1'b0, carB_en = 1'b1;
  logic [5:0] hall_led, carA_call, carB_call;
  logic       grant_vld, grant_car;
  logic [2:0] grant_idx;

  elevator_dispatcher #(.MOVE_PENALTY(P), .COST_W(4)) dut (
    .clk(clk), .rst(rst), .hall_btn(hall_btn),
    .carA_floor(carA_floor), .carA_dir(carA_dir), .carA_door(carA_door), .carA_en(carA_en),
    .carB_floor(carB_floor), .carB_dir(carB_dir), .carB_door(carB_door), .carB_en(carB_en),
    .hall_led(hall_led), .carA_call(carA_call), .carB_call(carB_call),
    .grant_vld(grant_vld), .grant_car(grant_car), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: each call is either pending or owned by a car (0 none, 1 A, 2 B)
  bit m_pend[6];
  int m_own[6];
  int m_phase, m_cur, m_ca, m_cb, m_rr, m_tie_last;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cfloor(input int i);
    if (i == 0) return 0;
    if (i <= 2) return 1;
    if (i <= 4) return 2;
    return 3;
  endfunction

  function automatic int cost(input int f, input int d, input bit en, input int cf);
    int c;
    if (!en) return 15;
    c = (f > cf) ? f - cf : cf - f;
    if ((d == 2 && cf < f) || (d == 1 && cf > f)) c += P;
    return c;
  endfunction

  function automatic int winner();
    if (carA_en && !carB_en) return 0;
    if (!carA_en && carB_en) return 1;
    if (m_ca < m_cb) return 0;
    if (m_cb < m_ca) return 1;
    return (m_tie_last == 1) ? 0 : 1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 6; i++) begin
      m_pend[i] = 0;
      m_own[i]  = 0;
    end
    m_phase = 0; m_cur = 0; m_ca = 0; m_cb = 0; m_rr = 0; m_tie_last = 1;
  endfunction

  task automatic model_check();
    int led, ca, cb, vld;
    led = 0; ca = 0; cb = 0;
    for (int i = 0; i < 6; i++) begin
      if (m_pend[i] || m_own[i] != 0) led |= (1 << i);
      if (m_own[i] == 1) ca |= (1 << i);
      if (m_own[i] == 2) cb |= (1 << i);
    end
    vld = (m_phase == 3 && (carA_en || carB_en)) ? 1 : 0;
    chk("m_hall_led", int'(hall_led), led);
    chk("m_carA_call", int'(carA_call), ca);
    chk("m_carB_call", int'(carB_call), cb);
    chk("m_grant_vld", int'(grant_vld), vld);
    if (vld == 1 && grant_vld) begin
      chk("m_grant_car", int'(grant_car), winner());
      chk("m_grant_idx", int'(grant_idx), m_cur);
    end
  endtask

  function automatic void model_update();
    bit any, g, ra, rb, busy[6];
    int w;
    any = 0;
    for (int i = 0; i < 6; i++) any |= m_pend[i];
    g = (m_phase == 3) && (carA_en || carB_en);
    w = winner();
    for (int i = 0; i < 6; i++) begin
      ra = (m_own[i] == 1) && carA_door && (cfloor(i) == int'(carA_floor));
      rb = (m_own[i] == 2) && carB_door && (cfloor(i) == int'(carB_floor));
      busy[i] = m_pend[i] || (m_own[i] == 1 && !ra) || (m_own[i] == 2 && !rb);
      if (ra || rb) m_own[i] = 0;
    end
    if (g) begin
      m_pend[m_cur] = 0;
      if (w == 0 && !(carA_door && cfloor(m_cur) == int'(carA_floor))) m_own[m_cur] = 1;
      if (w == 1 && !(carB_door && cfloor(m_cur) == int'(carB_floor))) m_own[m_cur] = 2;
      if (carA_en && carB_en && m_ca == m_cb) m_tie_last = w;
      m_rr = (m_cur + 1) % 6;
    end
    case (m_phase)
      0: if (any && (carA_en || carB_en)) m_phase = 1;
      1: begin
        for (int k = 5; k >= 0; k--)
          if (m_pend[(m_rr + k) % 6]) m_cur = (m_rr + k) % 6;
        m_phase = 2;
      end
      2: begin
        m_ca = cost(carA_floor, carA_dir, carA_en, cfloor(m_cur));
        m_cb = cost(carB_floor, carB_dir, carB_en, cfloor(m_cur));
        m_phase = 3;
      end
      default: m_phase = 0;
    endcase
    for (int i = 0; i < 6; i++)
      if (hall_btn[i] && !busy[i]) m_pend[i] = 1;
  endfunction

  task automatic step();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    hall_btn = '0; carA_door = 0; carB_door = 0;
    model_reset();
    @(negedge clk);
    #1;
    chk("reset_led", int'(hall_led), 0);
    chk("reset_vld", int'(grant_vld), 0);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_cars(input int af, input int ad, input int bf, input int bd, input bit ae, input bit be);
    carA_floor = 2'(af); carA_dir = 2'(ad); carB_floor = 2'(bf); carB_dir = 2'(bd);
    carA_en = ae; carB_en = be;
  endtask

  task automatic press(input logic [5:0] b);
    hall_btn = b;
    step();
    hall_btn = '0;
  endtask

  task automatic wait_grant(input int budget, output int idx, output int car, output int waited);
    bit ok;
    ok = 0; idx = -1; car = -1; waited = budget;
    for (int n = 0; n < budget && !ok; n++) begin
      #1;
      if (grant_vld) begin
        idx = grant_idx; car = grant_car; waited = n; ok = 1;
      end
      step();
    end
    if (!ok) chk("grant_timeout", 0, 1);
  endtask

  typedef struct {
    int af, ad, bf, bd;
    bit ae, be;
    int idx;
    int exp_car;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int idx, car, waited;
    tbl[0] = '{af:0, ad:0, bf:3, bd:0, ae:1, be:1, idx:5, exp_car:1};
    tbl[1] = '{af:1, ad:2, bf:0, bd:0, ae:1, be:1, idx:0, exp_car:1};
    tbl[2] = '{af:1, ad:0, bf:1, bd:0, ae:1, be:1, idx:3, exp_car:0};
    tbl[3] = '{af:0, ad:2, bf:3, bd:1, ae:1, be:1, idx:4, exp_car:1};
    tbl[4] = '{af:2, ad:1, bf:0, bd:0, ae:1, be:1, idx:5, exp_car:1};
    tbl[5] = '{af:2, ad:1, bf:3, bd:2, ae:1, be:1, idx:1, exp_car:0};
    tbl[6] = '{af:0, ad:0, bf:3, bd:0, ae:0, be:1, idx:0, exp_car:1};
    tbl[7] = '{af:3, ad:2, bf:0, bd:0, ae:1, be:0, idx:0, exp_car:0};
    model_reset();

    for (int v = 0; v < 8; v++) begin
      do_reset();
      set_cars(tbl[v].af, tbl[v].ad, tbl[v].bf, tbl[v].bd, tbl[v].ae, tbl[v].be);
      press(6'(1 << tbl[v].idx));
      step(); step(); step();
      #1;
      chk($sformatf("vec%0d_vld", v), int'(grant_vld), 1);
      chk($sformatf("vec%0d_car", v), int'(grant_car), tbl[v].exp_car);
      chk($sformatf("vec%0d_idx", v), int'(grant_idx), tbl[v].idx);
      step();
      chk($sformatf("vec%0d_call", v),
          int'(tbl[v].exp_car ? carB_call : carA_call), 1 << tbl[v].idx);
      chk($sformatf("vec%0d_led", v), int'(hall_led), 1 << tbl[v].idx);
    end

    // Retire on door open at the call floor
    do_reset();
    set_cars(1, 2, 0, 0, 1, 1);
    press(6'b000001);
    wait_grant(8, idx, car, waited);
    chk("ret_car", car, 1);
    chk("ret_pre", int'(carB_call), 1);
    carB_door = 1'b1;
    step();
    carB_door = 1'b0;
    chk("ret_call", int'(carB_call[0]), 0);
    chk("ret_led", int'(hall_led[0]), 0);

    // Ties alternate starting with A
    do_reset();
    set_cars(1, 0, 1, 0, 1, 1);
    press(6'b001000);
    wait_grant(8, idx, car, waited);
    chk("tie1_car", car, 0);
    press(6'b010000);
    wait_grant(8, idx, car, waited);
    chk("tie2_car", car, 1);
    chk("tie2_idx", idx, 4);

    // Round-robin over simultaneous presses, then wrap back to idx0
    do_reset();
    set_cars(0, 0, 3, 0, 1, 1);
    press(6'b100011);
    wait_grant(8, idx, car, waited);
    chk("rr1_idx", idx, 0);
    chk("rr1_lat", waited, 3);
    wait_grant(8, idx, car, waited);
    chk("rr2_idx", idx, 1);
    chk("rr2_slot", waited, 3);
    wait_grant(8, idx, car, waited);
    chk("rr3_idx", idx, 5);
    chk("rr3_car", car, 1);
    chk("rr3_slot", waited, 3);
    carA_door = 1'b1;
    step();
    carA_door = 1'b0;
    press(6'b010001);
    wait_grant(8, idx, car, waited);
    chk("wrap_idx", idx, 0);
    wait_grant(8, idx, car, waited);
    chk("wrap2_idx", idx, 4);

    // No car in service: call is held until B comes back
    do_reset();
    set_cars(0, 0, 3, 0, 0, 0);
    press(6'b000010);
    for (int n = 0; n < 8; n++) step();
    chk("dis_led", int'(hall_led), 2);
    chk("dis_vld", int'(grant_vld), 0);
    carB_en = 1'b1;
    wait_grant(8, idx, car, waited);
    chk("dis_car", car, 1);
    chk("dis_idx", idx, 1);

    // Asynchronous reset in the middle of a scan
    do_reset();
    set_cars(0, 0, 3, 0, 1, 1);
    press(6'b100001);
    step(); step();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_led", int'(hall_led), 0);
    chk("arst_a", int'(carA_call), 0);
    chk("arst_b", int'(carB_call), 0);
    chk("arst_vld", int'(grant_vld), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 6; n++) step();
    chk("arst_after", int'(hall_led), 0);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 800; n++) begin
      for (int b = 0; b < 6; b++) hall_btn[b] = ($urandom_range(0, 9) == 0);
      carA_floor = 2'($urandom_range(0, 3));
      carB_floor = 2'($urandom_range(0, 3));
      carA_dir   = 2'($urandom_range(0, 3));
      carB_dir   = 2'($urandom_range(0, 3));
      carA_door  = ($urandom_range(0, 3) == 0);
      carB_door  = ($urandom_range(0, 3) == 0);
      carA_en    = ($urandom_range(0, 7) != 0);
      carB_en    = ($urandom_range(0, 7) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elevator_dispatcher.md
Name: elevator_dispatcher

Overview:
Group controller for a two-car, four-floor installation. Latches the six hall-call buttons once, picks the cheaper car for each call, and drives that call as a level into the chosen car's outdoor-call inputs. Retires each call when the assigned car opens its door at the call floor. Sits above two elevator car controllers and owns the shared hall-button LEDs.

Parameters:
MOVE_PENALTY, 4, cost added when a car is moving away from the call floor (1..8)
COST_W, 4, width of the cost arithmetic; must hold 3+MOVE_PENALTY

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
hall_btn  in  6  hall buttons, level-sampled, bits 0..5 = U1,U2,D2,U3,D3,D4
carA_floor  in  2  car A floor (00=1F .. 11=4F)
carA_dir  in  2  car A direction (10 up, 01 down, 00 hold)
carA_door  in  1  car A door_open
carA_en  in  1  car A in service
carB_floor, carB_dir, carB_door, carB_en  in  2/2/1/1  same for car B
hall_led  out  6  pend|asgA|asgB
carA_call  out  6  calls assigned to A, same bit order as hall_btn
carB_call  out  6  calls assigned to B
grant_vld  out  1  one-cycle pulse per assignment
grant_car  out  1  0=A, 1=B; valid with grant_vld
grant_idx  out  3  call index 0..5; valid with grant_vld

Behaviour:
- Call floors: idx0→0, idx1/2→1, idx3/4→2, idx5→3.
- Reset (rst=0, any time including mid-scan): pend, asgA, asgB, grant_* = 0; FSM=IDLE; rr_ptr=0; tie_last=B. All outputs 0 next cycle after release.
- Latch: at each edge, a hall_btn bit that is 1 sets its pend bit, unless that bit is already set in pend, asgA or asgB. A press on a bit that is being retired in the same cycle re-enters pend.
- FSM: IDLE→PICK when pend!=0 and (carA_en|carB_en); otherwise stay in IDLE. PICK: select the first set pend bit searching from rr_ptr upward, wrapping 5→0; register it as cur. Always →COST. COST: register costA and costB. Always →GRANT. GRANT: assign cur, pulse grant_vld, set rr_ptr=cur+1 (5 wraps to 0). Always →IDLE.
- Cost per car: |car_floor − call_floor|, plus MOVE_PENALTY if (dir=10 and call_floor<car_floor) or (dir=01 and call_floor>car_floor). A disabled car's cost is treated as maximum.
- Winner: lower cost. On a tie, the car opposite tie_last wins, and tie_last is updated. If only one car is enabled, that car wins regardless of cost.
- Enable dropped between PICK and GRANT: if neither car is enabled at GRANT, no grant is issued, the pend bit stays set, and the FSM returns to IDLE.
- Assignment: clear pend[cur]; set asgX[cur] for the winning car. Latency: press latched at edge k, FSM idle → grant_vld high in the cycle after edge k+3.
- Retire: when carX_door=1, clear every asgX bit whose call floor equals carX_floor, both directions. Retire takes priority over a same-cycle grant of that bit to that car; grant_vld still pulses.
- Disabling a car does not reassign its existing asg bits. They stay asserted until retired.
- carA_call and carB_call are disjoint at all times. hall_led is registered-derived and glitch-free.

Test Plan:
- Reset, then A at 1F hold, B at 4F hold; press D4 (idx5) for 1 cycle → grant_vld 4 edges later with grant_car=1, grant_idx=5; carB_call=6'b100000; hall_led[5]=1.
- A at 2F dir=10, B at 1F hold; press U1 → costA=1+4=5, costB=0 → B granted. Then B door=1 at 1F → carB_call[0] clears next edge and hall_led[0]=0.
- Both cars at 2F hold; press U3, then press D3 after the first grant → ties alternate: first call to A (tie_last=B at reset), second to B.
- Press U1, U2, D4 on the same cycle → grants in order idx0, 1, 5 on consecutive 4-cycle slots; rr_ptr wrap checked by then pressing U1 while rr_ptr=0 after idx5.
- carA_en=0, carB_en=0; press U2 → no grant, hall_led[1]=1 held. Raise carB_en → granted to B.
- Assert rst low during COST with two pending calls → all outputs 0. Release → no grant until the buttons are pressed again.
